// File: rtl/clock_monitor_pkg.sv
//==============================================================================
// Module   : clock_monitor_pkg
// Desc     : Shared state type, window helpers and parameter checks for the
//            divided-clock period monitor.
// Revision : 1.0
//==============================================================================
`default_nettype none

package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } mon_state_t;

    localparam int C_DEF_NOMINAL_PERIOD = 336;
    localparam int C_DEF_TOLERANCE      = 4;
    localparam int C_DEF_WIN_LO         = C_DEF_NOMINAL_PERIOD - C_DEF_TOLERANCE;
    localparam int C_DEF_WIN_HI         = C_DEF_NOMINAL_PERIOD + C_DEF_TOLERANCE;

    function automatic int win_lo(input int nominal, input int tol);
        return nominal - tol;
    endfunction

    function automatic int win_hi(input int nominal, input int tol);
        return nominal + tol;
    endfunction

    // The counter must be able to hold TIMEOUT without wrapping.
    function automatic bit cnt_width_ok(input int cnt_w, input int timeout);
        if (cnt_w >= 32)
            return 1'b1;
        return (longint'(1) << cnt_w) > longint'(timeout);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//==============================================================================
// Module   : sync_edge_detect
// Desc     : Multi-flop synchronizer with registered-level edge detection.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("sync_edge_detect: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_period_monitor.sv
//==============================================================================
// Module   : clock_period_monitor
// Desc     : Measures period/high time of a divided clock in clk cycles,
//            qualifies lock against a nominal window and flags a lost clock.
// Revision : 1.0
//==============================================================================
`default_nettype none

module clock_period_monitor
    import clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int NOMINAL_PERIOD = 336,
    parameter int TOLERANCE      = 4,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT        = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             clock_lost
);

    if (!cnt_width_ok(CNT_W, TIMEOUT)) begin : g_cnt_width_check
        $error("clock_period_monitor: 2**CNT_W must exceed TIMEOUT");
    end

    localparam int               c_GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] c_WIN_LO     = CNT_W'(win_lo(NOMINAL_PERIOD, TOLERANCE));
    localparam logic [CNT_W-1:0] c_WIN_HI     = CNT_W'(win_hi(NOMINAL_PERIOD, TOLERANCE));
    localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [c_GOOD_W-1:0] c_LOCK_COUNT = c_GOOD_W'(LOCK_COUNT);

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sample_clk),
        .level    (w_level),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    mon_state_t          r_state;
    mon_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_GOOD_W-1:0] w_good_nxt;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    w_period_nxt;
    logic [CNT_W-1:0]    r_high;
    logic [CNT_W-1:0]    w_high_nxt;
    logic                r_pv;
    logic                w_pv_nxt;
    logic                r_inr;
    logic                w_inr_nxt;
    logic                r_locked;
    logic                w_locked_nxt;
    logic                r_lost;
    logic                w_lost_nxt;
    logic [CNT_W-1:0]    w_meas;
    logic                w_in_win;
    logic                w_timeout;

    // The value measured at an edge includes the edge cycle itself.
    assign w_meas     = r_cnt + CNT_W'(1);
    assign w_in_win   = (w_meas >= c_WIN_LO) && (w_meas <= c_WIN_HI);
    assign w_timeout  = (r_cnt == c_TIMEOUT_M1) && !w_rise;
    assign w_good_inc = r_good + c_GOOD_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt != c_TIMEOUT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_good   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_pv     <= 1'b0;
            r_inr    <= 1'b0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_pv     <= w_pv_nxt;
            r_inr    <= w_inr_nxt;
            r_locked <= w_locked_nxt;
            r_lost   <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_pv_nxt     = 1'b0;
        w_inr_nxt    = r_inr;
        w_locked_nxt = r_locked;
        w_lost_nxt   = r_lost;

        if (w_fall && !w_level && (r_state == ST_ACQUIRE || r_state == ST_LOCKED))
            w_high_nxt = w_meas;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_ACQUIRE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOST;
                    w_lost_nxt  = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (w_rise) begin
                    w_period_nxt = w_meas;
                    w_inr_nxt    = w_in_win;
                    w_pv_nxt     = 1'b1;
                    if (!w_in_win) begin
                        w_good_nxt = '0;
                    end else begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_LOCK_COUNT) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_nxt  = ST_LOST;
                    w_lost_nxt   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_good_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    w_period_nxt = w_meas;
                    w_inr_nxt    = w_in_win;
                    w_pv_nxt     = 1'b1;
                    if (!w_in_win) begin
                        w_state_nxt  = ST_ACQUIRE;
                        w_good_nxt   = '0;
                        w_locked_nxt = 1'b0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt  = ST_LOST;
                    w_lost_nxt   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_good_nxt   = '0;
                end
            end
            ST_LOST: begin
                // The interval ending on this rise spans the outage, so no strobe.
                if (w_rise) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_lost_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign period       = r_period;
    assign high_time    = r_high;
    assign period_valid = r_pv;
    assign in_range     = r_inr;
    assign locked       = r_locked;
    assign clock_lost   = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
//==============================================================================
// Module   : tb_clock_period_monitor
// Desc     : Table-driven bench for clock_period_monitor with hand sequences
//            for clock loss and asynchronous reset.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_clock_period_monitor;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             sample_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             clock_lost;

    clock_period_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sample_clk   (sample_clk),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .in_range     (in_range),
        .locked       (locked),
        .clock_lost   (clock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int high;
        int low;
        int exp_period;
        int exp_high;
        int exp_inr;
        int exp_locked;
    } vec_t;

    vec_t vecs[28];
    vec_t exp_q[$];
    vec_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_v(input int idx, input int h, input int l, input int p,
                         input int ht, input int inr, input int lk);
        vecs[idx] = '{idx, h, l, p, ht, inr, lk};
    endtask

    task automatic drive_period(input int h, input int l);
        sample_clk = 1'b1;
        repeat (h) @(negedge clk);
        sample_clk = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back(vecs[i]);
            drive_period(vecs[i].high, vecs[i].low);
        end
    endtask

    task automatic wait_pv(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (period_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " strobe seen"}, int'(seen), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " period"},       int'(period),       0);
        check({tag, " high_time"},    int'(high_time),    0);
        check({tag, " period_valid"}, int'(period_valid), 0);
        check({tag, " in_range"},     int'(in_range),     0);
        check({tag, " locked"},       int'(locked),       0);
        check({tag, " clock_lost"},   int'(clock_lost),   0);
    endtask

    // Every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (rst && period_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected period_valid at %0t: period %0d", $time, period);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d period", e.id),     int'(period),     e.exp_period);
                check($sformatf("v%0d high_time", e.id),  int'(high_time),  e.exp_high);
                check($sformatf("v%0d in_range", e.id),   int'(in_range),   e.exp_inr);
                check($sformatf("v%0d locked", e.id),     int'(locked),     e.exp_locked);
                check($sformatf("v%0d clock_lost", e.id), int'(clock_lost), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit lost_seen;

        // id, high, low, period, high_time, in_range, locked
        for (int i = 0; i < 5; i++) set_v(i, 168, 168, 336, 168, 1, (i >= 3) ? 1 : 0);
        set_v(5, 170, 171, 341, 170, 0, 0);
        for (int i = 6; i < 10; i++) set_v(i, 168, 168, 336, 168, 1, (i == 9) ? 1 : 0);
        set_v(10, 166, 166, 332, 166, 1, 1);
        set_v(11, 170, 170, 340, 170, 1, 1);
        set_v(12, 165, 166, 331, 165, 0, 0);
        set_v(13, 170, 171, 341, 170, 0, 0);
        set_v(14, 100, 236, 336, 100, 1, 0);
        set_v(15, 168, 168, 336, 168, 1, 0);
        set_v(16, 168, 168, 336, 168, 1, 0);
        set_v(17, 168, 168, 336, 168, 1, 1);
        for (int i = 18; i < 23; i++) set_v(i, 168, 168, 336, 168, 1, (i >= 21) ? 1 : 0);
        for (int i = 23; i < 28; i++) set_v(i, 168, 168, 336, 168, 1, (i >= 26) ? 1 : 0);

        rst        = 1'b0;
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Lock, out-of-window loss, re-lock, window edges, duty cycle.
        run_vectors(0, 17);

        // Final rise then the clock stops low.
        sample_clk = 1'b1;
        wait_pv("pre-loss");
        n = 0;
        lost_seen = 1'b0;
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (n == 160) sample_clk = 1'b0;
            if (clock_lost) begin
                lost_seen = 1'b1;
                break;
            end
        end
        check("clock_lost asserted", int'(lost_seen), 1);
        check("clock_lost latency", n, 1024);
        check("locked at loss", int'(locked), 0);
        repeat (20) @(negedge clk);
        check("clock_lost held", int'(clock_lost), 1);

        // Restart: first rise gives no strobe.
        run_vectors(18, 22);

        // Asynchronous reset while locked.
        sample_clk = 1'b1;
        wait_pv("pre-reset");
        repeat (20) @(negedge clk);
        check("locked before reset", int'(locked), 1);
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        sample_clk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_vectors(23, 27);
        sample_clk = 1'b1;
        repeat (10) @(negedge clk);
        check("pending strobes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
